bcd_countdown: RTL and testbench

- Two-digit BCD down-counter (mm or ss field, modulus 60 by default), the counting-down counterpart of the team's up-counting seconds block.
- Loads a BCD preset, then decrements once per qualified tick and stops at 00.
- Raises a borrow pulse and a done flag at 00, for kitchen-timer and countdown experiments driving the same 7-segment display path.
- Output data uses the same {tens, units} BCD packing as the up-counters, so display logic is shared.

---
 rtl/bcd_pkg.sv | 16 +
 rtl/bcd_countdown_if.sv | 24 ++
 rtl/bcd_digit_dec.sv | 25 ++
 rtl/bcd_countdown.sv | 148 ++++++++++++++
 tb/tb_bcd_countdown.sv | 211 +++++++++++++++++++++
 5 files changed

// File: rtl/bcd_pkg.sv
// Shared types and constants for the BCD countdown block.
package bcd_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } state_e;

    typedef logic [3:0] bcd_digit_t;

    localparam bcd_digit_t BCD_DIGIT_MAX = 4'd9;
    localparam bcd_digit_t BCD_ZERO      = 4'd0;

endpackage

// File: rtl/bcd_countdown_if.sv
// Control strobes and count/status outputs of the BCD countdown block.
interface bcd_countdown_if;

    logic       tick;
    logic       load;
    logic [7:0] load_data;
    logic       start;
    logic       pause;
    logic [7:0] data;
    logic       borrow;
    logic       done;
    logic       busy;

    modport master (
        output tick, load, load_data, start, pause,
        input  data, borrow, done, busy
    );

    modport slave (
        input  tick, load, load_data, start, pause,
        output data, borrow, done, busy
    );

endinterface

// File: rtl/bcd_digit_dec.sv
// Combinational single BCD digit decrement; wraps 0 to max_i and raises borrow.
module bcd_digit_dec
    import bcd_pkg::*;
(
    input  bcd_digit_t digit_i,
    input  logic       borrow_i,
    input  bcd_digit_t max_i,
    output bcd_digit_t digit_o_c,
    output logic       borrow_o_c
);

    always_comb begin
        digit_o_c  = digit_i;
        borrow_o_c = 1'b0;
        if (borrow_i) begin
            if (digit_i == BCD_ZERO) begin
                digit_o_c  = max_i;
                borrow_o_c = 1'b1;
            end else begin
                digit_o_c = digit_i - 4'd1;
            end
        end
    end

endmodule

// File: rtl/bcd_countdown.sv
// Two-digit BCD down-counter with load/start/pause control, borrow pulse and done flag.
// Optional: define BCD_COUNTDOWN_AUTO_RELOAD_EN to reload the last preset after reaching 00.
module bcd_countdown
    import bcd_pkg::*;
#(
    parameter int unsigned MAX_TENS  = 5,
    parameter int unsigned MAX_UNITS = 9
) (
    input  logic            CP,
    input  logic            RST,
    bcd_countdown_if.slave  bus
);

    localparam bcd_digit_t TENS_MAX  = 4'(MAX_TENS);
    localparam bcd_digit_t UNITS_MAX = (MAX_UNITS > 32'(BCD_DIGIT_MAX)) ? BCD_DIGIT_MAX
                                                                         : 4'(MAX_UNITS);
    localparam logic [7:0] CLAMP_VAL = {TENS_MAX, UNITS_MAX};

    state_e     state_q, state_d;
    logic [7:0] count_q, count_d;
    logic       borrow_q, borrow_d;
    logic       done_q, done_d;
    logic       busy_q, busy_d;
`ifdef BCD_COUNTDOWN_AUTO_RELOAD_EN
    logic [7:0] reload_q, reload_d;
`endif

    logic [7:0] load_val;
    bcd_digit_t units_dec, tens_dec;
    logic       units_bo, tens_bo;
    logic [7:0] dec_val;

    // An out-of-range digit anywhere clamps the whole preset.
    always_comb begin
        load_val = bus.load_data;
        if ((bus.load_data[3:0] > UNITS_MAX) || (bus.load_data[7:4] > TENS_MAX)) begin
            load_val = CLAMP_VAL;
        end
    end

    bcd_digit_dec u_units (
        .digit_i    (count_q[3:0]),
        .borrow_i   (1'b1),
        .max_i      (UNITS_MAX),
        .digit_o_c  (units_dec),
        .borrow_o_c (units_bo)
    );

    bcd_digit_dec u_tens (
        .digit_i    (count_q[7:4]),
        .borrow_i   (units_bo),
        .max_i      (TENS_MAX),
        .digit_o_c  (tens_dec),
        .borrow_o_c (tens_bo)
    );

    assign dec_val = {tens_dec, units_dec};

    // tens_bo is set exactly when the current count is 00.
    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        done_d   = done_q;
        borrow_d = 1'b0;
`ifdef BCD_COUNTDOWN_AUTO_RELOAD_EN
        reload_d = reload_q;
`endif
        case (state_q)
            IDLE, PAUSE: begin
                if (bus.load) begin
                    count_d = load_val;
`ifdef BCD_COUNTDOWN_AUTO_RELOAD_EN
                    reload_d = load_val;
`endif
                end
                if (bus.start && (count_d != 8'h00)) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (bus.pause) begin
                    state_d = PAUSE;
                end else if (bus.tick) begin
                    if (!tens_bo) begin
                        count_d = dec_val;
                        if (dec_val == 8'h00) begin
                            borrow_d = 1'b1;
`ifdef BCD_COUNTDOWN_AUTO_RELOAD_EN
                            if (reload_q == 8'h00) begin
                                state_d = DONE;
                                done_d  = 1'b1;
                            end
`else
                            state_d = DONE;
                            done_d  = 1'b1;
`endif
                        end
                    end
`ifdef BCD_COUNTDOWN_AUTO_RELOAD_EN
                    else begin
                        count_d = reload_q;
                    end
`endif
                end
            end
            DONE: begin
                if (bus.load) begin
                    count_d = load_val;
                    done_d  = 1'b0;
                    state_d = IDLE;
`ifdef BCD_COUNTDOWN_AUTO_RELOAD_EN
                    reload_d = load_val;
`endif
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d == RUN);
    end

    always_ff @(posedge CP or negedge RST) begin
        if (!RST) begin
            state_q  <= IDLE;
            count_q  <= 8'h00;
            borrow_q <= 1'b0;
            done_q   <= 1'b0;
            busy_q   <= 1'b0;
`ifdef BCD_COUNTDOWN_AUTO_RELOAD_EN
            reload_q <= 8'h00;
`endif
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            borrow_q <= borrow_d;
            done_q   <= done_d;
            busy_q   <= busy_d;
`ifdef BCD_COUNTDOWN_AUTO_RELOAD_EN
            reload_q <= reload_d;
`endif
        end
    end

    assign bus.data   = count_q;
    assign bus.borrow = borrow_q;
    assign bus.done   = done_q;
    assign bus.busy   = busy_q;

endmodule

// File: tb/tb_bcd_countdown.sv
// Directed self-checking bench for bcd_countdown (default and auto-reload builds).
module tb_bcd_countdown;

`ifdef BCD_COUNTDOWN_AUTO_RELOAD_EN
    localparam bit AUTO = 1'b1;
`else
    localparam bit AUTO = 1'b0;
`endif

    logic CP;
    logic RST;
    int   checks;
    int   errors;

    bcd_countdown_if bus ();

    bcd_countdown #(.MAX_TENS(5), .MAX_UNITS(9)) dut (
        .CP  (CP),
        .RST (RST),
        .bus (bus)
    );

    initial begin
        CP = 1'b0;
        forever #5 CP = ~CP;
    end

    task automatic cycle();
        @(posedge CP);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic [7:0] d, input logic b,
                           input logic dn, input logic by);
        chk({tag, ".data"},   bus.data,          d);
        chk({tag, ".borrow"}, 8'(bus.borrow),    8'(b));
        chk({tag, ".done"},   8'(bus.done),      8'(dn));
        chk({tag, ".busy"},   8'(bus.busy),      8'(by));
    endtask

    task automatic idle_inputs();
        bus.tick = 1'b0; bus.load = 1'b0; bus.load_data = 8'h00;
        bus.start = 1'b0; bus.pause = 1'b0;
    endtask

    logic [7:0] seq12 [12];
    logic [7:0] seq_ar [8];

    initial begin
        checks = 0;
        errors = 0;
        seq12  = '{8'h11, 8'h10, 8'h09, 8'h08, 8'h07, 8'h06,
                   8'h05, 8'h04, 8'h03, 8'h02, 8'h01, 8'h00};
        seq_ar = '{8'h02, 8'h01, 8'h00, 8'h03, 8'h02, 8'h01, 8'h00, 8'h03};
        idle_inputs();
        RST = 1'b0;
        cycle();
        cycle();
        chk_out("reset", 8'h00, 1'b0, 1'b0, 1'b0);
        RST = 1'b1;
        cycle();

        // Full run from 12 down to 00
        bus.load = 1'b1; bus.load_data = 8'h12;
        cycle();
        idle_inputs();
        chk_out("load12", 8'h12, 1'b0, 1'b0, 1'b0);
        bus.start = 1'b1;
        cycle();
        idle_inputs();
        chk_out("start12", 8'h12, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 12; i++) begin
            bus.tick = 1'b1;
            cycle();
            chk_out($sformatf("run12[%0d]", i), seq12[i], (i == 11), (i == 11) && !AUTO,
                    (i != 11) || AUTO);
        end
        idle_inputs();
        cycle();
        chk_out("after00", 8'h00, 1'b0, !AUTO, AUTO);
        bus.pause = 1'b1;
        cycle();
        idle_inputs();
        chk_out("pause_at00", 8'h00, 1'b0, !AUTO, 1'b0);
        bus.start = 1'b1;
        cycle();
        idle_inputs();
        chk_out("start_at00", 8'h00, 1'b0, !AUTO, 1'b0);

        // Clamp on load, load ignored while running
        bus.load = 1'b1; bus.load_data = 8'h7A;
        cycle();
        idle_inputs();
        chk_out("clamp7A", 8'h59, 1'b0, 1'b0, 1'b0);
        bus.start = 1'b1;
        cycle();
        idle_inputs();
        bus.tick = 1'b1;
        cycle();
        chk_out("run58", 8'h58, 1'b0, 1'b0, 1'b1);
        bus.load = 1'b1; bus.load_data = 8'h30;
        cycle();
        idle_inputs();
        chk_out("load_in_run", 8'h57, 1'b0, 1'b0, 1'b1);
        bus.tick = 1'b1;
        cycle();
        idle_inputs();
        chk_out("run56", 8'h56, 1'b0, 1'b0, 1'b1);

        // Async reset while running at 37
        bus.pause = 1'b1;
        cycle();
        idle_inputs();
        bus.load = 1'b1; bus.load_data = 8'h37;
        cycle();
        idle_inputs();
        chk_out("load37", 8'h37, 1'b0, 1'b0, 1'b0);
        bus.start = 1'b1;
        cycle();
        idle_inputs();
        chk_out("run37", 8'h37, 1'b0, 1'b0, 1'b1);
        RST = 1'b0;
        #1;
        chk_out("async_rst", 8'h00, 1'b0, 1'b0, 1'b0);
        bus.tick = 1'b1; bus.load = 1'b1; bus.load_data = 8'h45; bus.start = 1'b1;
        cycle();
        chk_out("held_rst", 8'h00, 1'b0, 1'b0, 1'b0);
        idle_inputs();
        RST = 1'b1;
        cycle();
        chk_out("post_rst", 8'h00, 1'b0, 1'b0, 1'b0);

        // Pause with tick in the same cycle, then resume
        bus.load = 1'b1; bus.load_data = 8'h20;
        cycle();
        idle_inputs();
        bus.start = 1'b1;
        cycle();
        idle_inputs();
        bus.tick = 1'b1;
        cycle(); cycle(); cycle();
        chk_out("run17", 8'h17, 1'b0, 1'b0, 1'b1);
        bus.pause = 1'b1;
        cycle();
        bus.pause = 1'b0;
        chk_out("pause17", 8'h17, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            cycle();
            chk({"hold17_", $sformatf("%0d", i)}, bus.data, 8'h17);
        end
        idle_inputs();
        bus.start = 1'b1;
        cycle();
        idle_inputs();
        chk_out("resume17", 8'h17, 1'b0, 1'b0, 1'b1);
        bus.tick = 1'b1;
        cycle();
        chk(("run16"), bus.data, 8'h16);
        cycle();
        idle_inputs();
        chk_out("run15", 8'h15, 1'b0, 1'b0, 1'b1);

        // Priority: pause beats start; zero start ignored; load+start judged on loaded value
        bus.pause = 1'b1; bus.start = 1'b1;
        cycle();
        idle_inputs();
        chk_out("pause_wins", 8'h15, 1'b0, 1'b0, 1'b0);
        bus.load = 1'b1; bus.load_data = 8'h00; bus.start = 1'b1;
        cycle();
        idle_inputs();
        chk_out("zero_start", 8'h00, 1'b0, 1'b0, 1'b0);
        cycle();
        chk_out("zero_stay", 8'h00, 1'b0, 1'b0, 1'b0);
        bus.load = 1'b1; bus.load_data = 8'h05; bus.start = 1'b1;
        cycle();
        idle_inputs();
        chk_out("load_start05", 8'h05, 1'b0, 1'b0, 1'b1);

`ifdef BCD_COUNTDOWN_AUTO_RELOAD_EN
        // Auto reload from 03
        bus.pause = 1'b1;
        cycle();
        idle_inputs();
        bus.load = 1'b1; bus.load_data = 8'h03;
        cycle();
        idle_inputs();
        bus.start = 1'b1;
        cycle();
        idle_inputs();
        for (int i = 0; i < 8; i++) begin
            bus.tick = 1'b1;
            cycle();
            chk_out($sformatf("reload[%0d]", i), seq_ar[i], (i == 2) || (i == 6), 1'b0, 1'b1);
        end
        idle_inputs();
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
